// File: rtl/modn_pkg.sv
// Shared types and helpers for the mod-N down timer.
package modn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ceiling log2, used at elaboration to check that WIDTH can hold N-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/modn_down_core.sv
// Count register with reload storage: decrement, wrap-to-reload and zero detect.
module modn_down_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  input  logic             reload_en,
  output logic [WIDTH-1:0] q,
  output logic             is_zero
);

  logic [WIDTH-1:0] reload;

  assign is_zero = (q == '0);

  // clr beats ld beats dec; ld_val arrives already clamped to 0..N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      reload <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q      <= ld_val;
      reload <= ld_val;
    end else if (dec) begin
      if (!is_zero)       q <= q - WIDTH'(1);
      else if (reload_en) q <= reload;
    end
  end

endmodule

// File: rtl/modn_down_timer.sv
// Mod-N down timer: load handshake, one-shot/periodic terminal count, tc pulse,
// clamp error pulse and saturating terminal-event count.
module modn_down_timer
  import modn_pkg::*;
#(
  parameter int N     = 6,
  parameter int WIDTH = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             en,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             load_err,
  output logic [CW-1:0]    wrap_cnt
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(N - 1);

  if (N < 2 || clog2(N) > WIDTH) begin : g_bad_params
    $error("modn_down_timer: need N >= 2 and 2**WIDTH >= N");
  end

  state_t           state;
  logic             mode_r;
  logic             accept;
  logic             over;
  logic             dec;
  logic             is_zero;
  logic [WIDTH-1:0] ld_val;

  assign load_ready = (state == IDLE) || (state == DONE);
  assign busy       = (state == RUN)  || (state == HOLD);

  // stop outranks a load presented on the same edge.
  assign accept = load_valid && load_ready && !stop;
  assign over   = {{(32-WIDTH){1'b0}}, load_value} >= 32'(N);
  assign ld_val = over ? MAXV : load_value;
  assign dec    = (state == RUN) && en && !pause && !stop;

  modn_down_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (stop),
    .ld        (accept),
    .ld_val    (ld_val),
    .dec       (dec),
    .reload_en (mode_r),
    .q         (q),
    .is_zero   (is_zero)
  );

  // Control FSM with registered tc/load_err pulses and the terminal-event count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      tc       <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else if (accept) begin
        state    <= RUN;
        mode_r   <= mode;
        wrap_cnt <= '0;
        load_err <= over;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (en && is_zero) begin
              tc <= 1'b1;
              if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + CW'(1);
              if (!mode_r) state <= DONE;
            end
          end
          HOLD:    if (!pause) state <= RUN;
          default: ;
        endcase
      end
    end
  end

endmodule
